// File: rtl/data_memory_responder.sv
// Single-port data memory behind a valid/ready request/response handshake.
// Writes commit on the accept edge; read data and the range error are registered for the response.
module data_memory_responder #(
  parameter logic [31:0] BASE_ADDR   = 32'h0000_1000,
  parameter int unsigned DEPTH_WORDS = 8192
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [31:0] addr_i,
  input  logic [3:0]  write_mask_i,
  input  logic [31:0] write_data_i,
  output logic        rsp_valid_o,
  input  logic        rsp_ready_i,
  output logic [31:0] read_data_o,
  output logic        rsp_error_o
);

  localparam int unsigned AW        = $clog2(DEPTH_WORDS);
  localparam logic [31:0] LAST_ADDR = BASE_ADDR + 32'(4 * DEPTH_WORDS) - 32'd1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t      state, state_nxt;
  logic [31:0] mem [DEPTH_WORDS];
  logic [31:0] offset;
  logic [AW-1:0] idx;
  logic        in_range;
  logic        accept;
  logic        unused_offset;

  // Request stage: captured at accept
  logic [AW-1:0] idx_p0;
  logic          rd_p0;
  // Response stage: registered on ACCESS -> RESP
  logic [31:0]   rdata_p1;
  logic          err_p1;

  assign offset        = addr_i - BASE_ADDR;
  assign idx           = offset[AW+1:2];
  assign unused_offset = ^{offset[31:AW+2], offset[1:0]};
  assign in_range      = (addr_i >= BASE_ADDR) && (addr_i <= LAST_ADDR);

  assign req_ready_o = (state == IDLE) && !rst_i;
  assign accept      = req_valid_i && req_ready_o;
  assign rsp_valid_o = (state == RESP);
  assign read_data_o = rdata_p1;
  assign rsp_error_o = err_p1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    if (rsp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Store commits on the accept edge so a reset during ACCESS cannot lose it.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      idx_p0 <= idx;
      if (in_range) begin
        for (int b = 0; b < 4; b++) begin
          if (write_mask_i[b]) mem[idx][8*b +: 8] <= write_data_i[8*b +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_p0    <= 1'b0;
      rdata_p1 <= '0;
      err_p1   <= 1'b0;
    end else begin
      if (accept) begin
        rd_p0    <= in_range && (write_mask_i == 4'b0000);
        rdata_p1 <= '0;
        err_p1   <= !in_range;
      end else if (state == ACCESS) begin
        rdata_p1 <= rd_p0 ? mem[idx_p0] : 32'h0;
      end else if ((state == RESP) && rsp_ready_i) begin
        rdata_p1 <= '0;
        err_p1   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/data_memory_responder.md
DATA_MEMORY_RESPONDER -- requirements
Module: data_memory_responder

Interface
REQ-001 SHALL have parameter BASE_ADDR, default 32'h0000_1000, meaning the byte address of data memory word 0.
REQ-002 SHALL have parameter DEPTH_WORDS, default 8192, meaning the number of 32-bit words (32 KiB, 0x1000-0x8FFF).
REQ-003 SHALL use one clock and an asynchronous, active-high reset: clk_i  in  1  rising-edge clock.
REQ-004 SHALL have rst_i  in  1  asynchronous active-high reset.
REQ-005 SHALL have req_valid_i  in  1  request present.
REQ-006 SHALL have req_ready_o  out  1  responder can accept a request.
REQ-007 SHALL have addr_i  in  32  byte address; bits [1:0] ignored.
REQ-008 SHALL have write_mask_i  in  4  byte-lane write enables (bit n -> bits [8n+7:8n]); 4'b0000 = read.
REQ-009 SHALL have write_data_i  in  32  store data, lane-aligned to the mask.
REQ-010 SHALL have rsp_valid_o  out  1  response present.
REQ-011 SHALL have rsp_ready_i  in  1  requester accepts response.
REQ-012 SHALL have read_data_o  out  32  full word read; 0 for writes and errors.
REQ-013 SHALL have rsp_error_o  out  1  address out of range.

Function
REQ-014 SHALL implement FSM states IDLE, ACCESS, RESP.
REQ-015 SHALL drive req_ready_o = 1 only in IDLE with rst_i low; accept = req_valid_i & req_ready_o on a rising edge.
REQ-016 SHALL, on accept, capture addr_i, write_mask_i, write_data_i and go IDLE -> ACCESS; the requester need not hold inputs afterwards.
REQ-017 SHALL compute word index = (addr_i - BASE_ADDR) >> 2, 32-bit unsigned arithmetic.
REQ-018 SHALL flag in-range iff BASE_ADDR <= addr_i <= BASE_ADDR + 4*DEPTH_WORDS - 1.
REQ-019 SHALL, for an in-range write (mask != 0), update exactly the masked lanes on the accept edge; unmasked lanes are unchanged.
REQ-020 SHALL, for an in-range read (mask == 0), register the addressed word on the ACCESS -> RESP edge.
REQ-021 SHALL always go ACCESS -> RESP after exactly one cycle.
REQ-022 SHALL drive rsp_valid_o = 1 only in RESP, so the response appears two edges after the accept edge.
REQ-023 SHALL hold read_data_o and rsp_error_o stable while rsp_valid_o = 1 and rsp_ready_i = 0.
REQ-024 SHALL go RESP -> IDLE on the edge where rsp_ready_i = 1; minimum request spacing is 3 cycles.
REQ-025 SHALL make read_data_o = 32'h0 for writes and for out-of-range accesses.
REQ-026 SHALL, for out-of-range accesses, set rsp_error_o = 1 and perform no memory write.
REQ-027 SHALL ignore req_valid_i outside IDLE, with no capture and no write.
REQ-028 SHALL give rsp_ready_i no effect outside RESP.
REQ-029 SHALL make a read after a completed write to the same word return the merged word (no stale data).

Reset
REQ-030 SHALL, while rst_i = 1, force state IDLE, req_ready_o = 0, rsp_valid_o = 0, read_data_o = 0, rsp_error_o = 0.
REQ-031 SHALL, on reset mid-operation (ACCESS or RESP), discard the pending response; a write already accepted remains committed.
REQ-032 SHALL NOT clear memory contents on reset; power-up contents are undefined.
REQ-033 SHALL assert req_ready_o on the first cycle after rst_i deasserts.

Verification
REQ-034 SHALL cover: write 0xFF00AACC, mask 1111 @0x1000, then read @0x1000 -> rsp 0xFF00AACC, error 0, rsp_valid two edges after each accept.
REQ-035 SHALL cover: then write 0x00000055, mask 0001 @0x1000, then read -> 0xFF00AA55; write 0x00001234, mask 0011, then read -> 0xFF001234.
REQ-036 SHALL cover: read @0x8FFC (last word, after writing 0xDEADBEEF) -> 0xDEADBEEF, error 0; read @0x9000 and @0x0FFC -> data 0, error 1.
REQ-037 SHALL cover: write mask 1111 @0x9000 -> error 1, then read @0x1000 -> contents unchanged.
REQ-038 SHALL cover: hold rsp_ready_i = 0 for 5 cycles in RESP -> rsp_valid_o and data stable, req_ready_o = 0, extra req_valid_i ignored; release -> IDLE next edge.
REQ-039 SHALL cover: assert rst_i while in ACCESS for a write of 0x11223344 @0x1004 -> rsp_valid_o = 0 immediately; after reset, read @0x1004 -> 0x11223344.
